echo_scheduler: RTL and testbench
=================================

Name: echo_scheduler

Overview:
Frame sequencer that shares one delay memory and one registered Q2.14 multiplier between NUM_CH echo channels. Clocked by bclk. Each lrclk frame it runs one input-gain/read/feedback/write slot per channel. After reset it zero-fills the memory before the first slot. Sits between the I2S sample path and the memory and multiplier instances; the multiplier and memory stay outside this block.

Parameters:
BITSIZE, 16, sample and gain width; gains Q2.14, 0x4000 = 1.0
NUM_CH, 2, channels served per frame; memory split into NUM_CH equal regions
PTRLEN, 14, per-channel ring pointer width
ADDRLEN, 15, memory address width; must be ≥ PTRLEN + clog2(NUM_CH)

Ports:
bclk  in  1  sole clock, 64× lrclk
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  0 = flush mode, outputs muted
lrclk  in  1  frame clock; rising edge starts a frame
length  in  PTRLEN  delay in frames; sampled at frame start
input_gain  in  BITSIZE  signed Q2.14
feedback_gain  in  BITSIZE  signed Q2.14
in_bus  in  NUM_CH*BITSIZE  signed samples; ch0 in the LSBs
out_bus  out  NUM_CH*BITSIZE  delayed samples, registered
mem_addr  out  ADDRLEN  address = {ch, ptr}
mem_wren  out  1  write strobe
mem_datain  out  BITSIZE  write data
mem_dataout  in  BITSIZE  read data, valid 1 cycle after mem_addr
mult_in1, mult_in2  out  BITSIZE  multiplier operands
mult_out  in  BITSIZE  product >>> 14, valid 1 cycle after operands
busy  out  1  high from the frame-start edge through DONE
cleaning  out  1  high during post-reset zero fill
frame_overrun  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n = 0):
  - all outputs 0, except cleaning = 1 and state = CLEAN.
  - wr_ptr = 0 and clean_addr = 0.
- lrclk is registered once; frame_start = lrclk & ~lrclk_q.
- CLEAN:
  - each cycle: mem_wren = 1, mem_datain = 0, mem_addr = clean_addr, clean_addr++.
  - after address 2**ADDRLEN−1 is written: cleaning goes to 0 and state goes to IDLE.
  - frame_start is ignored while cleaning; out_bus stays 0.
- IDLE: on frame_start:
  - latch length; a latched value of 0 is forced to 1.
  - latch in_bus; set busy = 1; set ch = 0; go to MUL_IN.
- Per-channel slot, 4 cycles:
  - MUL_IN: mult_in1 = in[ch], mult_in2 = input_gain, mem_addr = {ch, wr_ptr − len} (mod 2**PTRLEN), mem_wren = 0.
  - FB: aux = mult_out; out[ch] = enable ? mem_dataout : 0; mult_in1 = mem_dataout, mult_in2 = feedback_gain.
  - WR: mem_addr = {ch, wr_ptr}, mem_wren = 1. mem_datain = enable ? sat(aux + mult_out) : 0.
  - NEXT: mem_wren = 0. If ch < NUM_CH−1: ch++, go to MUL_IN. Otherwise go to DONE.
- DONE: wr_ptr++ (wraps at 2**PTRLEN), busy = 0, go to IDLE.
- Frame cost is 4*NUM_CH + 1 cycles; NUM_CH = 2 gives 9 cycles, well inside 64 bclk.
- Arithmetic: sat() is a BITSIZE+1-bit add clamped to [−2**(BITSIZE−1), 2**(BITSIZE−1)−1].
- Overrun: frame_start while busy sets frame_overrun. That edge is dropped and the running sequence completes. The flag clears only on reset.
- Enable low: the sequence still runs, so memory flushes to zero at the write pointer, and out_bus is forced to 0.
- Reset mid-frame: immediate return to CLEAN, and the full zero fill is repeated.
- length ≥ 2**PTRLEN cannot occur (port width). len = 2**PTRLEN−1 reads the slot about to be overwritten next frame; this is legal.

Test Plan:
1. Reset, hold lrclk low → cleaning high for exactly 2**ADDRLEN cycles, every address written 0, then cleaning = 0 and busy = 0.
2. After clean: input_gain = 0x4000, feedback_gain = 0, length = 3, impulse 0x1000 on ch0 in frame 0 → out ch0 = 0x1000 in frame 3 only; ch1 stays 0.
3. feedback_gain = 0x2000, length = 2, impulse 0x2000 → ch0 output 0x2000, 0x1000, 0x0800 at frames 2, 4, 6.
4. in = 0x7000, input_gain = 0x4000, feedback_gain = 0x4000, length = 1, sustained → mem_datain saturates at 0x7FFF, never wraps negative.
5. Second lrclk rising edge 4 cycles after the first → frame_overrun = 1, the current 9-cycle sequence completes, wr_ptr increments once.
6. enable = 0 for 5 frames with echo present, then enable = 1 → out_bus 0 throughout; afterwards the delayed output is 0 until fresh input arrives.

Source files
------------

// File: rtl/echo_scheduler.sv
// Frame sequencer for NUM_CH echo channels sharing one delay memory and one Q2.14 multiplier.
// Runs a 4-cycle gain/read/feedback/write slot per channel each lrclk frame, after a post-reset zero fill.
module echo_scheduler #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned PTRLEN  = 14,
  parameter int unsigned ADDRLEN = 15
) (
  input  logic                        bclk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        lrclk,
  input  logic [PTRLEN-1:0]           length,
  input  logic [BITSIZE-1:0]          input_gain,
  input  logic [BITSIZE-1:0]          feedback_gain,
  input  logic [NUM_CH*BITSIZE-1:0]   in_bus,
  output logic [NUM_CH*BITSIZE-1:0]   out_bus,
  output logic [ADDRLEN-1:0]          mem_addr,
  output logic                        mem_wren,
  output logic [BITSIZE-1:0]          mem_datain,
  input  logic [BITSIZE-1:0]          mem_dataout,
  output logic [BITSIZE-1:0]          mult_in1,
  output logic [BITSIZE-1:0]          mult_in2,
  input  logic [BITSIZE-1:0]          mult_out,
  output logic                        busy,
  output logic                        cleaning,
  output logic                        frame_overrun
);

  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_CLEAN, S_IDLE, S_MUL_IN, S_FB, S_WR, S_NEXT, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [CHW-1:0]       ch, ch_d;
  logic [PTRLEN-1:0]    len, len_d;
  logic [PTRLEN-1:0]    wr_ptr, wr_ptr_d;
  logic [PTRLEN-1:0]    rd_ptr;
  logic [ADDRLEN-1:0]   clean_addr, clean_addr_d;
  logic [BITSIZE-1:0]   aux, aux_d;
  logic [BITSIZE-1:0]   in_lat [NUM_CH];
  logic [BITSIZE-1:0]   in_d   [NUM_CH];
  logic [BITSIZE-1:0]   out_q  [NUM_CH];
  logic [BITSIZE-1:0]   out_d  [NUM_CH];
  logic [ADDRLEN-1:0]   addr_d;
  logic                 wren_d, busy_d, cleaning_d, overrun_d;
  logic                 lrclk_q;
  logic                 frame_start;
  logic [BITSIZE:0]     wr_sum;
  logic [BITSIZE-1:0]   sat_val;

  assign frame_start = lrclk & ~lrclk_q;

  // State and registered outputs
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_CLEAN;
      ch            <= '0;
      len           <= '0;
      wr_ptr        <= '0;
      clean_addr    <= '0;
      aux           <= '0;
      lrclk_q       <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        in_lat[i] <= '0;
        out_q[i]  <= '0;
      end
      mem_addr      <= '0;
      mem_wren      <= 1'b0;
      busy          <= 1'b0;
      cleaning      <= 1'b1;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_d;
      ch            <= ch_d;
      len           <= len_d;
      wr_ptr        <= wr_ptr_d;
      clean_addr    <= clean_addr_d;
      aux           <= aux_d;
      lrclk_q       <= lrclk;
      in_lat        <= in_d;
      out_q         <= out_d;
      mem_addr      <= addr_d;
      mem_wren      <= wren_d;
      busy          <= busy_d;
      cleaning      <= cleaning_d;
      frame_overrun <= overrun_d;
    end
  end

  // Next state; memory address/strobe are set on entry to the state that uses them
  always_comb begin
    state_d      = state;
    ch_d         = ch;
    len_d        = len;
    wr_ptr_d     = wr_ptr;
    clean_addr_d = clean_addr;
    aux_d        = aux;
    in_d         = in_lat;
    out_d        = out_q;
    addr_d       = mem_addr;
    wren_d       = 1'b0;
    busy_d       = busy;
    cleaning_d   = cleaning;
    overrun_d    = frame_overrun | (frame_start & busy);
    rd_ptr       = '0;

    case (state)
      S_CLEAN: begin
        addr_d       = clean_addr;
        wren_d       = 1'b1;
        clean_addr_d = clean_addr + 1'b1;
        if (clean_addr == '1) begin
          cleaning_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        if (frame_start) begin
          len_d = (length == '0) ? PTRLEN'(1) : length;
          for (int i = 0; i < int'(NUM_CH); i++) begin
            in_d[i] = in_bus[i*BITSIZE +: BITSIZE];
          end
          busy_d  = 1'b1;
          ch_d    = '0;
          rd_ptr  = wr_ptr - len_d;
          addr_d  = ADDRLEN'({ch_d, rd_ptr});
          state_d = S_MUL_IN;
        end
      end
      S_MUL_IN: state_d = S_FB;
      S_FB: begin
        aux_d     = mult_out;
        out_d[ch] = enable ? mem_dataout : '0;
        addr_d    = ADDRLEN'({ch, wr_ptr});
        wren_d    = 1'b1;
        state_d   = S_WR;
      end
      S_WR: state_d = S_NEXT;
      S_NEXT: begin
        if (ch == CHW'(NUM_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch + 1'b1;
          rd_ptr  = wr_ptr - len;
          addr_d  = ADDRLEN'({ch_d, rd_ptr});
          state_d = S_MUL_IN;
        end
      end
      S_DONE: begin
        wr_ptr_d = wr_ptr + 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands must reach the multiplier in the same cycle mem_dataout becomes valid
  always_comb begin
    mult_in1 = '0;
    mult_in2 = '0;
    if (state == S_MUL_IN) begin
      mult_in1 = in_lat[ch];
      mult_in2 = input_gain;
    end else if (state == S_FB) begin
      mult_in1 = mem_dataout;
      mult_in2 = feedback_gain;
    end
  end

  // Saturating sum of input term and feedback term
  assign wr_sum = {aux[BITSIZE-1], aux} + {mult_out[BITSIZE-1], mult_out};

  always_comb begin
    if (wr_sum[BITSIZE] == wr_sum[BITSIZE-1]) begin
      sat_val = wr_sum[BITSIZE-1:0];
    end else if (wr_sum[BITSIZE]) begin
      sat_val = {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(BITSIZE-1){1'b1}}};
    end
  end

  assign mem_datain = (state == S_WR && enable) ? sat_val : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_bus[g*BITSIZE +: BITSIZE] = out_q[g];
  end

endmodule

// File: tb/tb_echo_scheduler.sv
// Directed bench for echo_scheduler: external memory/multiplier models plus a frame-level delay-line model.
module tb_echo_scheduler;

  logic        bclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lrclk;
  logic [13:0] length;
  logic [15:0] input_gain, feedback_gain;
  logic [31:0] in_bus;
  logic [31:0] out_bus;
  logic [14:0] mem_addr;
  logic        mem_wren;
  logic [15:0] mem_datain;
  logic [15:0] mem_dataout;
  logic [15:0] mult_in1, mult_in2;
  logic [15:0] mult_out;
  logic        busy, cleaning, frame_overrun;

  echo_scheduler dut (
    .bclk(bclk), .rst_n(rst_n), .enable(enable), .lrclk(lrclk), .length(length),
    .input_gain(input_gain), .feedback_gain(feedback_gain), .in_bus(in_bus),
    .out_bus(out_bus), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_out(mult_out),
    .busy(busy), .cleaning(cleaning), .frame_overrun(frame_overrun)
  );

  always #5 bclk = ~bclk;

  int nchk = 0;
  int nbad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] qmul(input logic signed [15:0] a, input logic signed [15:0] b);
    int p;
    p = int'(a) * int'(b);
    return 16'(p >>> 14);
  endfunction

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  // External synchronous memory and registered multiplier
  logic [15:0] mem [32768];
  always @(posedge bclk) begin
    if (mem_wren) mem[mem_addr] <= mem_datain;
    mem_dataout <= mem[mem_addr];
    mult_out    <= qmul(mult_in1, mult_in2);
  end

  // Frame-level model: one ring buffer per channel
  typedef struct packed { logic [14:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] ring [2][16384];
  int          wp;
  logic [31:0] exp_out;
  logic        exp_ovr;

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 16384; k++) ring[c][k] = 16'h0;
    wp = 0;
    exp_out = 32'h0;
    exp_ovr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [15:0] i0, input logic [15:0] i1, input logic [13:0] len,
                            input logic [15:0] ig, input logic [15:0] fg, input logic en);
    logic [15:0] ins [2];
    logic [15:0] rd, wv;
    logic [13:0] rp;
    int l;
    ins[0] = i0;
    ins[1] = i1;
    l  = (len == 14'd0) ? 1 : int'(len);
    rp = 14'(wp - l);
    for (int c = 0; c < 2; c++) begin
      rd = ring[c][rp];
      exp_out[c*16 +: 16] = en ? rd : 16'h0;
      wv = en ? sat16(int'($signed(qmul(ins[c], ig))) + int'($signed(qmul(rd, fg)))) : 16'h0;
      ring[c][wp] = wv;
      exp_q.push_back('{addr: 15'(c * 16384 + wp), data: wv});
    end
    wp = (wp + 1) % 16384;
  endtask

  // Per-cycle compare: every slot write, and frame outputs when busy falls
  logic        busy_prev = 1'b0;
  logic        track = 1'b0;
  logic [15:0] last_w0 = 16'h0;
  int          neg_seen = 0;
  wr_t         e;

  always @(negedge bclk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (mem_wren && busy) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_datain), 32'(e.data));
          if (track && !mem_addr[14]) begin
            last_w0 = mem_datain;
            if (mem_datain[15]) neg_seen++;
          end
        end
      end
      if (busy_prev && !busy) begin
        check("frame_out", out_bus, exp_out);
        check("frame_ovr", 32'(frame_overrun), 32'(exp_ovr));
      end
      busy_prev = busy;
    end
  end

  task automatic frame(input logic [15:0] i0, input logic [15:0] i1, input logic [13:0] len,
                       input logic [15:0] ig, input logic [15:0] fg, input logic en, input bit ovr);
    int bc;
    @(negedge bclk);
    in_bus = {i1, i0};
    length = len;
    input_gain = ig;
    feedback_gain = fg;
    enable = en;
    model_step(i0, i1, len, ig, fg, en);
    if (ovr) exp_ovr = 1'b1;
    lrclk = 1'b1;
    bc = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge bclk);
      if (busy) bc++;
      if (ovr && c == 0) lrclk = 1'b0;
      if (ovr && c == 3) lrclk = 1'b1;
    end
    check("busy_cycles", 32'(bc), 32'd9);
    lrclk = 1'b0;
    repeat (32) @(negedge bclk);
  endtask

  task automatic wait_clean(input bit toggle);
    int n, bsy, nz;
    n = 0;
    bsy = 0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge bclk);
      if (!cleaning) break;
      n++;
      if (busy) bsy++;
      if (toggle && (k % 32) == 31) lrclk = ~lrclk;
    end
    check("clean_cycles", 32'(n), 32'd32768);
    check("busy_in_clean", 32'(bsy), 32'd0);
    lrclk = 1'b0;
    repeat (40) @(negedge bclk);
    check("after_clean", {29'd0, cleaning, busy, frame_overrun}, 32'd0);
    check("out_after_clean", out_bus, 32'h0);
    nz = 0;
    for (int a = 0; a < 32768; a++) if (mem[a] !== 16'h0) nz++;
    check("mem_zeroed", 32'(nz), 32'd0);
  endtask

  logic [31:0] t3_exp [7] = '{32'h0, 32'h0, 32'h2000, 32'h0, 32'h1000, 32'h0, 32'h0800};

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 16'hDEAD;
    rst_n = 1'b0;
    enable = 1'b1;
    lrclk = 1'b0;
    length = 14'd0;
    input_gain = 16'h0;
    feedback_gain = 16'h0;
    in_bus = 32'h0;
    model_reset();

    // Reset state
    repeat (3) @(negedge bclk);
    check("rst_cleaning", 32'(cleaning), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", out_bus, 32'h0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_ovr", 32'(frame_overrun), 32'd0);
    @(posedge bclk);
    #2 rst_n = 1'b1;
    wait_clean(1'b0);

    // Plain delay, no feedback
    for (int f = 0; f < 6; f++) begin
      frame((f == 0) ? 16'h1000 : 16'h0, 16'h0, 14'd3, 16'h4000, 16'h0, 1'b1, 1'b0);
      check("t2_out", out_bus, (f == 3) ? 32'h0000_1000 : 32'h0);
    end

    // Half-gain feedback echo train
    for (int f = 0; f < 7; f++) begin
      frame((f == 0) ? 16'h2000 : 16'h0, 16'h0, 14'd2, 16'h4000, 16'h2000, 1'b1, 1'b0);
      check("t3_out", out_bus, t3_exp[f]);
    end

    // Saturation under unity feedback
    track = 1'b1;
    for (int f = 0; f < 6; f++) frame(16'h7000, 16'h0, 14'd1, 16'h4000, 16'h4000, 1'b1, 1'b0);
    track = 1'b0;
    check("t4_sat_value", 32'(last_w0), 32'h7FFF);
    check("t4_no_wrap", 32'(neg_seen), 32'd0);

    // Overrun: second edge dropped, sequence completes once
    frame(16'h0123, 16'h0456, 14'd4, 16'h4000, 16'h0, 1'b1, 1'b1);
    check("t5_ovr_flag", 32'(frame_overrun), 32'd1);
    frame(16'h0, 16'h0, 14'd4, 16'h4000, 16'h0, 1'b1, 1'b0);
    check("t5_ovr_sticky", 32'(frame_overrun), 32'd1);

    // Enable low flushes memory and mutes output
    frame(16'h0AAA, 16'h1111, 14'd3, 16'h4000, 16'h0, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      frame(16'h0777, 16'h0777, 14'd3, 16'h4000, 16'h0, 1'b0, 1'b0);
      check("t6_muted", out_bus, 32'h0);
    end
    for (int f = 0; f < 4; f++) begin
      frame(16'h0, 16'h0, 14'd3, 16'h4000, 16'h0, 1'b1, 1'b0);
      check("t6_flushed", out_bus, 32'h0);
    end
    frame(16'h0321, 16'h0, 14'd3, 16'h4000, 16'h0, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) frame(16'h0, 16'h0, 14'd3, 16'h4000, 16'h0, 1'b1, 1'b0);
    check("t6_fresh", out_bus, 32'h0000_0321);
    check("q_drained_1", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame
    @(negedge bclk);
    in_bus = 32'h0101_0202;
    length = 14'd2;
    model_step(16'h0202, 16'h0101, 14'd2, 16'h4000, 16'h0, 1'b1);
    lrclk = 1'b1;
    repeat (5) @(negedge bclk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cleaning", 32'(cleaning), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovr", 32'(frame_overrun), 32'd0);
    check("midrst_out", out_bus, 32'h0);
    model_reset();
    lrclk = 1'b0;
    repeat (3) @(negedge bclk);
    @(posedge bclk);
    #2 rst_n = 1'b1;
    wait_clean(1'b1);

    // Length 0 behaves as 1; maximum length reads the slot ahead
    frame(16'h0555, 16'h0666, 14'd0, 16'h4000, 16'h0, 1'b1, 1'b0);
    frame(16'h0, 16'h0, 14'd0, 16'h4000, 16'h0, 1'b1, 1'b0);
    check("len0_as_1", out_bus, 32'h0666_0555);
    frame(16'h0, 16'h0, 14'h3FFF, 16'h4000, 16'h0, 1'b1, 1'b0);
    check("len_max", out_bus, 32'h0);
    check("q_drained_2", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
